// File: rtl/frogger_game_state_pkg.sv
// Shared constants for the frogger game-state slice: state encoding, row
// constants and score/lives widths used by the position controller and display.
package frogger_game_state_pkg;

  localparam int SCORE_W          = 7;
  localparam int LIVES_W          = 3;
  localparam int HIT_CNT_W        = 8;
  localparam int DEFAULT_GOAL_ROW = 0;
  localparam int START_ROW        = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  // Saturating score increment; callers guarantee max fits in SCORE_W bits.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score,
                                                    input logic [SCORE_W-1:0] max);
    return (score >= max) ? max : score + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frogger_game_state_if.sv
// Bundle between the frog draw/position stage and the game-state controller.
// The slave side is the game-state controller itself.
interface frogger_game_state_if #(
  parameter int ROW_W = 6
);
  import frogger_game_state_pkg::*;

  logic               i_Start;
  logic               i_Frame_Tick;
  logic               i_Draw_Frogger;
  logic               i_Draw_Car;
  logic [ROW_W-1:0]   i_Frogger_Y;

  logic               o_Game_Active;
  logic               o_Frog_Reset;
  logic [SCORE_W-1:0] o_Score;
  logic [LIVES_W-1:0] o_Lives;
  logic               o_Hit_Flash;
  logic               o_Game_Over;
  logic [1:0]         o_State;

  modport master (
    output i_Start, i_Frame_Tick, i_Draw_Frogger, i_Draw_Car, i_Frogger_Y,
    input  o_Game_Active, o_Frog_Reset, o_Score, o_Lives, o_Hit_Flash,
           o_Game_Over, o_State
  );

  modport slave (
    input  i_Start, i_Frame_Tick, i_Draw_Frogger, i_Draw_Car, i_Frogger_Y,
    output o_Game_Active, o_Frog_Reset, o_Score, o_Lives, o_Hit_Flash,
           o_Game_Over, o_State
  );

endinterface

// File: rtl/frogger_edge_det.sv
// Rising-edge detector: registers the previous level sample and flags a
// low-to-high transition in the cycle the input first reads high.
module frogger_edge_det (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Level,
  output logic o_Rise
);

  logic level_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_Level;
    end
  end

  assign o_Rise = i_Level & ~level_q;

endmodule

// File: rtl/frogger_game_state.sv
// Frogger game-state controller: collision/goal detection once per frame,
// score and lives bookkeeping, and the IDLE/PLAYING/HIT/OVER sequence.
module frogger_game_state
  import frogger_game_state_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int SCORE_MAX  = 99,
  parameter int HIT_FRAMES = 60,
  parameter int GOAL_ROW   = DEFAULT_GOAL_ROW,
  parameter int ROW_W      = 6
) (
  input logic                  i_Clk,
  input logic                  i_Rst_L,
  frogger_game_state_if.slave  gs
);

  localparam logic [LIVES_W-1:0]   LIVES_RST = LIVES_W'(LIVES_INIT);
  localparam logic [SCORE_W-1:0]   SCORE_SAT = SCORE_W'(SCORE_MAX);
  localparam logic [HIT_CNT_W-1:0] HIT_LOAD  = HIT_CNT_W'(HIT_FRAMES);
  localparam logic [ROW_W-1:0]     GOAL_Y    = ROW_W'(GOAL_ROW);

  game_state_t          state;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic                 coll_latch;
  logic                 start_rise;

  frogger_edge_det u_start_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Level (gs.i_Start),
    .o_Rise  (start_rise)
  );

  // Every PLAYING exit happens on a frame tick, so the tick clear also
  // covers clearing the latch on state exit.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state            <= ST_IDLE;
      hit_cnt          <= '0;
      coll_latch       <= 1'b0;
      gs.o_Score       <= '0;
      gs.o_Lives       <= LIVES_RST;
      gs.o_Game_Active <= 1'b0;
      gs.o_Frog_Reset  <= 1'b0;
      gs.o_Hit_Flash   <= 1'b0;
      gs.o_Game_Over   <= 1'b0;
    end else begin
      gs.o_Frog_Reset <= 1'b0;

      if (gs.i_Frame_Tick) begin
        coll_latch <= 1'b0;
      end else if (state == ST_PLAYING && gs.i_Draw_Frogger && gs.i_Draw_Car) begin
        coll_latch <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state            <= ST_PLAYING;
            gs.o_Score       <= '0;
            gs.o_Lives       <= LIVES_RST;
            gs.o_Frog_Reset  <= 1'b1;
            gs.o_Game_Active <= 1'b1;
            gs.o_Game_Over   <= 1'b0;
          end
        end

        ST_PLAYING: begin
          if (gs.i_Frame_Tick) begin
            if (coll_latch && gs.o_Lives == LIVES_W'(1)) begin
              state            <= ST_OVER;
              gs.o_Lives       <= '0;
              gs.o_Game_Active <= 1'b0;
              gs.o_Game_Over   <= 1'b1;
            end else if (coll_latch) begin
              state            <= ST_HIT;
              gs.o_Lives       <= gs.o_Lives - LIVES_W'(1);
              hit_cnt          <= HIT_LOAD;
              gs.o_Game_Active <= 1'b0;
              gs.o_Hit_Flash   <= 1'b1;
            end else if (gs.i_Frogger_Y == GOAL_Y) begin
              gs.o_Score      <= score_inc(gs.o_Score, SCORE_SAT);
              gs.o_Frog_Reset <= ~gs.o_Frog_Reset;
            end
          end
        end

        ST_HIT: begin
          if (gs.i_Frame_Tick) begin
            if (hit_cnt == HIT_CNT_W'(1)) begin
              state            <= ST_PLAYING;
              hit_cnt          <= '0;
              gs.o_Frog_Reset  <= 1'b1;
              gs.o_Game_Active <= 1'b1;
              gs.o_Hit_Flash   <= 1'b0;
            end else begin
              hit_cnt <= hit_cnt - HIT_CNT_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gs.o_State = state;

endmodule
